pio_input_conditioner: RTL and testbench

- Conditions raw, asynchronous board inputs (push-buttons, slide switches) before they reach the Avalon PIO input port.
- Per bit, it synchronises the input to `clk`, normalises polarity, and debounces with a per-bit stability counter.
- Drives the clean `in_port` vector that the PIO samples for software reads at address 0.
- Sits directly upstream of the PIO in the platform's NIOS/SDRAM system, in the same clock domain.

---
 rtl/pio_cond_pkg.sv | 19 +
 rtl/pio_debounce_bit.sv | 112 +++++++++++
 rtl/pio_input_conditioner.sv | 36 +++
 tb/tb_pio_input_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pio_cond_pkg.sv
// Shared constants, helper function and state type for the PIO input
// conditioner.
package pio_cond_pkg;

    localparam int PIO_COND_DEF_WIDTH    = 8;
    localparam int PIO_COND_DEF_SYNC     = 2;
    localparam int PIO_COND_DEF_DEBOUNCE = 50000;

    // Counter width able to hold every value from 0 up to n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } cond_state_t;

endpackage

// File: rtl/pio_debounce_bit.sv
// One conditioned input bit: synchroniser chain, polarity fix-up,
// stability counter with a STABLE/COUNTING state machine, and optional
// registered edge strobes (generated only with PIO_COND_EDGE_PULSE_EN).
module pio_debounce_bit
    import pio_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = PIO_COND_DEF_SYNC,
    parameter int   DEBOUNCE_CYCLES = PIO_COND_DEF_DEBOUNCE,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    cond_state_t            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;

    // Synchroniser chain; resets to the idle (released) pin level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // State, counter and accepted level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive differing samples; any agreeing sample restarts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sample != level_q) begin
                    if (CNT_LAST == '0) begin
                        level_d = sample;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (sample == level_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = sample;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
    end

    assign level_o = level_q;

`ifdef PIO_COND_EDGE_PULSE_EN
    logic rise_q, fall_q;

    // Strobes are computed from the next level so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= level_d & ~level_q;
            fall_q <= ~level_d & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/pio_input_conditioner.sv
// Conditions raw board inputs (buttons, switches) for the Avalon PIO
// in_port: per-bit synchronise, polarity normalise and debounce.
// Edge strobes are built only when PIO_COND_EDGE_PULSE_EN is defined;
// otherwise rise_pulse/fall_pulse are constant 0.
module pio_input_conditioner
    import pio_cond_pkg::*;
#(
    parameter int               WIDTH           = PIO_COND_DEF_WIDTH,
    parameter int               SYNC_STAGES     = PIO_COND_DEF_SYNC,
    parameter int               DEBOUNCE_CYCLES = PIO_COND_DEF_DEBOUNCE,
    parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW_MASK[i])
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_in[i]),
            .level_o(in_port[i]),
            .rise_o (rise_pulse[i]),
            .fall_o (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench for pio_input_conditioner with a per-cycle scoreboard of
// expected in_port / rise_pulse / fall_pulse values.
module tb_pio_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] raw_in;
    logic [7:0] in_port;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] inp;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t expQ[$];

`ifdef PIO_COND_EDGE_PULSE_EN
    localparam logic [7:0] PULSE_MASK = 8'hFF;
`else
    localparam logic [7:0] PULSE_MASK = 8'h00;
`endif

    pio_input_conditioner #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW_MASK(8'h0F)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .in_port   (in_port),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    // Drive new raw pin levels between clock edges.
    task automatic applyStimulus(input logic [7:0] r);
        raw_in = r;
    endtask

    // Queue n cycles of expected outputs.
    task automatic pushExp(input logic [7:0] inp, input logic [7:0] r,
                           input logic [7:0] f, input int n);
        exp_t e;
        e.inp  = inp;
        e.rise = r & PULSE_MASK;
        e.fall = f & PULSE_MASK;
        for (int k = 0; k < n; k++) expQ.push_back(e);
    endtask

    // Advance one clock and compare outputs against the scoreboard head.
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s scoreboard empty", tag);
        end else begin
            e = expQ.pop_front();
            total++;
            assert (in_port === e.inp) else begin
                bad++;
                $error("[TB] FAIL %s in_port got=%h exp=%h", tag, in_port, e.inp);
            end
            total++;
            assert (rise_pulse === e.rise) else begin
                bad++;
                $error("[TB] FAIL %s rise_pulse got=%h exp=%h", tag, rise_pulse, e.rise);
            end
            total++;
            assert (fall_pulse === e.fall) else begin
                bad++;
                $error("[TB] FAIL %s fall_pulse got=%h exp=%h", tag, fall_pulse, e.fall);
            end
        end
    endtask

    task automatic runCycles(input string tag, input int n);
        for (int k = 0; k < n; k++) checkOutput(tag);
    endtask

    initial begin
        // 1: reset with idle inputs (active-low nibble released)
        reset = 1'b1;
        applyStimulus(8'h0F);
        pushExp(8'h00, 8'h00, 8'h00, 3);
        runCycles("reset", 3);
        reset = 1'b0;
        pushExp(8'h00, 8'h00, 8'h00, 4);
        runCycles("idle", 4);

        // 2: bit 4 pressed and held, accepted on edge 6
        applyStimulus(8'h1F);
        pushExp(8'h00, 8'h00, 8'h00, 5);
        pushExp(8'h10, 8'h10, 8'h00, 1);
        pushExp(8'h10, 8'h00, 8'h00, 3);
        runCycles("rise4", 9);

        // 3: bit 5 high for only 3 clocks is rejected
        applyStimulus(8'h3F);
        pushExp(8'h10, 8'h00, 8'h00, 3);
        runCycles("short5a", 3);
        applyStimulus(8'h1F);
        pushExp(8'h10, 8'h00, 8'h00, 6);
        runCycles("short5b", 6);

        // 4: active-low bit 0 with a one-clock glitch restarting the count
        applyStimulus(8'h1E);
        pushExp(8'h10, 8'h00, 8'h00, 2);
        runCycles("glitch0a", 2);
        applyStimulus(8'h1F);
        pushExp(8'h10, 8'h00, 8'h00, 1);
        runCycles("glitch0b", 1);
        applyStimulus(8'h1E);
        pushExp(8'h10, 8'h00, 8'h00, 5);
        pushExp(8'h11, 8'h01, 8'h00, 1);
        pushExp(8'h11, 8'h00, 8'h00, 2);
        runCycles("glitch0c", 8);

        // back to idle: bits 0 and 4 fall together
        applyStimulus(8'h0F);
        pushExp(8'h11, 8'h00, 8'h00, 5);
        pushExp(8'h00, 8'h00, 8'h11, 1);
        pushExp(8'h00, 8'h00, 8'h00, 2);
        runCycles("fall04", 8);

        // 5: all eight bits change in one clock
        applyStimulus(8'hF0);
        pushExp(8'h00, 8'h00, 8'h00, 5);
        pushExp(8'hFF, 8'hFF, 8'h00, 1);
        pushExp(8'hFF, 8'h00, 8'h00, 2);
        runCycles("allrise", 8);

        applyStimulus(8'h0F);
        pushExp(8'hFF, 8'h00, 8'h00, 5);
        pushExp(8'h00, 8'h00, 8'hFF, 1);
        pushExp(8'h00, 8'h00, 8'h00, 2);
        runCycles("allfall", 8);

        // 6: reset on the 3rd clock of the acceptance count
        applyStimulus(8'hF0);
        pushExp(8'h00, 8'h00, 8'h00, 4);
        runCycles("midcnt", 4);
        reset = 1'b1;
        pushExp(8'h00, 8'h00, 8'h00, 2);
        runCycles("midrst", 2);
        reset = 1'b0;
        pushExp(8'h00, 8'h00, 8'h00, 5);
        pushExp(8'hFF, 8'hFF, 8'h00, 1);
        pushExp(8'hFF, 8'h00, 8'h00, 3);
        runCycles("postrst", 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
